// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: 2-flop synchroniser, consecutive-sample
// debounce, press/release pulses, optional auto-repeat and a priority code.
module btn_debounce_multi #(
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NUM_BTN-1:0] iBtn,
  input  logic [NUM_BTN-1:0] iRepeatEn,
  output logic [NUM_BTN-1:0] oLevel,
  output logic [NUM_BTN-1:0] oPress,
  output logic [NUM_BTN-1:0] oRelease,
  output logic [NUM_BTN-1:0] oRepeat,
  output logic               oAny,
  output logic [((NUM_BTN > 1) ? $clog2(NUM_BTN) : 1)-1:0] oCode
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = $clog2(RP_MAX);
  localparam int unsigned CODE_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic [NUM_BTN-1:0] repeat_q, repeat_d;
  logic [NUM_BTN-1:0] first_q, first_d;
  logic [DB_W-1:0]    cnt_q  [NUM_BTN];
  logic [DB_W-1:0]    cnt_d  [NUM_BTN];
  logic [RP_W-1:0]    rcnt_q [NUM_BTN];
  logic [RP_W-1:0]    rcnt_d [NUM_BTN];

  // Per-channel debounce and auto-repeat next state
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    first_d   = first_q;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      cnt_d[i]  = cnt_q[i];
      rcnt_d[i] = rcnt_q[i];
    end
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d[i]   = sync2_q[i];
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
        cnt_d[i]     = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end

      // Repeat timer is held cleared unless the button is held and enabled
      if (press_d[i]) begin
        rcnt_d[i]  = '0;
        first_d[i] = 1'b1;
      end else if (!level_q[i] || !iRepeatEn[i] || release_d[i]) begin
        rcnt_d[i]  = '0;
        first_d[i] = 1'b1;
      end else if (first_q[i] && (rcnt_q[i] == RP_W'(REPEAT_DELAY - 1))) begin
        repeat_d[i] = 1'b1;
        rcnt_d[i]   = '0;
        first_d[i]  = 1'b0;
      end else if (!first_q[i] && (rcnt_q[i] == RP_W'(REPEAT_PERIOD - 1))) begin
        repeat_d[i] = 1'b1;
        rcnt_d[i]   = '0;
      end else begin
        rcnt_d[i] = rcnt_q[i] + RP_W'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      first_q   <= '0;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        cnt_q[i]  <= '0;
        rcnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= iBtn;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      first_q   <= first_d;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        cnt_q[i]  <= cnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
      end
    end
  end

  // Highest-index pressed channel; derived from registered level only
  always_comb begin
    oCode = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      if (level_q[i]) oCode = CODE_W'(i);
    end
  end

  assign oAny     = |level_q;
  assign oLevel   = level_q;
  assign oPress   = press_q;
  assign oRelease = release_q;
  assign oRepeat  = repeat_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: constant vector tables for reset/bounce cases
// plus a window-based reference model feeding an expected-value queue.
module tb_btn_debounce_multi;

  localparam int N  = 5;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int CW = 3;

  logic          Clock, Reset;
  logic [N-1:0]  iBtn, iRepeatEn;
  logic [N-1:0]  oLevel, oPress, oRelease, oRepeat;
  logic          oAny;
  logic [CW-1:0] oCode;

  btn_debounce_multi #(
    .NUM_BTN(N), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iBtn(iBtn), .iRepeatEn(iRepeatEn),
    .oLevel(oLevel), .oPress(oPress), .oRelease(oRelease), .oRepeat(oRepeat),
    .oAny(oAny), .oCode(oCode)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct packed {
    logic [N-1:0]  lvl;
    logic [N-1:0]  prs;
    logic [N-1:0]  rel;
    logic [N-1:0]  rep;
    logic          any;
    logic [CW-1:0] code;
  } exp_t;

  typedef struct {
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_prs, n_rep, n_act;

  logic [N-1:0]  m_sync1, m_s, m_lvl;
  logic [DC-1:0] m_hist [N];
  int            m_arm  [N];

  logic          cur_rst;
  logic [N-1:0]  cur_btn, cur_en;

  function automatic exp_t mk_exp(input logic [N-1:0] lvl, prs, rel, rep);
    exp_t e;
    e.lvl = lvl; e.prs = prs; e.rel = rel; e.rep = rep;
    e.any = |lvl;
    e.code = '0;
    for (int i = 0; i < N; i++) if (lvl[i]) e.code = CW'(i);
    return e;
  endfunction

  // Level flips once the last DC synchronised samples all disagree with it;
  // repeats are timed from the most recent arm point.
  task automatic model_step(input logic rst, input logic [N-1:0] btn, en, output exp_t e);
    logic [N-1:0] prs, rel, rep;
    logic prev;
    int age;
    prs = '0; rel = '0; rep = '0;
    if (!rst) begin
      m_sync1 = '0; m_s = '0; m_lvl = '0;
      for (int i = 0; i < N; i++) begin
        m_hist[i] = '0;
        m_arm[i]  = cyc;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        prev = m_lvl[i];
        m_hist[i] = {m_hist[i][DC-2:0], m_s[i]};
        prs[i] = !prev && (&m_hist[i]);
        rel[i] = prev && (m_hist[i] == '0);
        if (prs[i]) m_lvl[i] = 1'b1;
        else if (rel[i]) m_lvl[i] = 1'b0;
        if (prs[i]) begin
          m_arm[i] = cyc;
        end else if (prev && en[i] && !rel[i]) begin
          age = cyc - m_arm[i];
          rep[i] = (age >= RD) && (((age - RD) % RP) == 0);
        end else begin
          m_arm[i] = cyc;
        end
        m_s[i]     = m_sync1[i];
        m_sync1[i] = btn[i];
      end
    end
    e = mk_exp(m_lvl, prs, rel, rep);
  endtask

  task automatic step(input logic rst, input logic [N-1:0] btn, en,
                      input bit use_tab, input exp_t tab_e, input string name);
    exp_t me, got, want;
    Reset = rst; iBtn = btn; iRepeatEn = en;
    cyc++;
    model_step(rst, btn, en, me);
    exp_q.push_back(use_tab ? tab_e : me);
    @(posedge Clock);
    #1;
    got  = {oLevel, oPress, oRelease, oRepeat, oAny, oCode};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc %0d: got lvl=%b prs=%b rel=%b rep=%b any=%b code=%0d, want lvl=%b prs=%b rel=%b rep=%b any=%b code=%0d",
               name, cyc, got.lvl, got.prs, got.rel, got.rep, got.any, got.code,
               want.lvl, want.prs, want.rel, want.rep, want.any, want.code);
    end
    n_prs += $countones(oPress);
    n_rep += $countones(oRepeat);
    n_act += $countones(oLevel | oPress | oRelease);
  endtask

  task automatic tick(input int n, input string name);
    exp_t dummy;
    dummy = '0;
    repeat (n) step(cur_rst, cur_btn, cur_en, 1'b0, dummy, name);
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic clr_counts();
    n_prs = 0; n_rep = 0; n_act = 0;
  endtask

  vec_t tab[22];
  int   b2[12] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    // Reset with all buttons held, then the bounce pattern on channel 2
    for (int r = 0; r < 10; r++) begin
      tab[r].rst = (r >= 3);
      tab[r].btn = 5'b11111;
      tab[r].lvl = (r >= 8) ? 5'b11111 : 5'b00000;
      tab[r].prs = (r == 8) ? 5'b11111 : 5'b00000;
    end
    for (int j = 0; j < 12; j++) begin
      tab[10+j].rst = 1'b1;
      tab[10+j].btn = N'(b2[j] << 2);
      tab[10+j].lvl = (j >= 10) ? 5'b00100 : 5'b00000;
      tab[10+j].prs = (j == 10) ? 5'b00100 : 5'b00000;
    end

    cur_rst = 1'b1; cur_btn = '0; cur_en = '0;
    clr_counts();

    for (int r = 0; r < 10; r++)
      step(tab[r].rst, tab[r].btn, '0, 1'b1, mk_exp(tab[r].lvl, tab[r].prs, '0, '0), "t1_reset_hold");
    cur_btn = '0;
    tick(8, "t1_release");

    for (int r = 10; r < 22; r++)
      step(tab[r].rst, tab[r].btn, '0, 1'b1, mk_exp(tab[r].lvl, tab[r].prs, '0, '0), "t2_bounce");
    cur_btn = '0;
    tick(8, "t2_release");

    clr_counts();
    cur_btn = 5'b00001;
    tick(3, "t3_glitch");
    cur_btn = '0;
    tick(8, "t3_glitch_after");
    check_val("t3_no_activity", n_act, 0);

    clr_counts();
    cur_en = 5'b00010; cur_btn = 5'b00010;
    tick(25, "t4_repeat_hold");
    check_val("t4_press_count", n_prs, 1);
    check_val("t4_repeat_count", n_rep, 4);
    cur_btn = '0;
    tick(10, "t4_repeat_release");

    clr_counts();
    cur_en = '0; cur_btn = 5'b00010;
    tick(25, "t4_norepeat_hold");
    check_val("t4_norepeat_count", n_rep, 0);
    cur_btn = '0;
    tick(8, "t4_norepeat_release");

    cur_btn = 5'b01010;
    tick(6, "t5_dual_press");
    check_val("t5_press_vec", int'(oPress), 10);
    check_val("t5_code3", int'(oCode), 3);
    check_val("t5_any1", int'(oAny), 1);
    cur_btn = 5'b00010;
    tick(6, "t5_release3");
    check_val("t5_code1", int'(oCode), 1);
    cur_btn = '0;
    tick(6, "t5_release_all");
    check_val("t5_any0", int'(oAny), 0);
    check_val("t5_code0", int'(oCode), 0);

    clr_counts();
    cur_en = 5'b10000; cur_btn = 5'b10000;
    tick(11, "t6_pre_reset");
    cur_rst = 1'b0;
    tick(1, "t6_reset");
    check_val("t6_reset_level", int'(oLevel), 0);
    cur_rst = 1'b1;
    clr_counts();
    tick(5, "t6_post_reset_wait");
    check_val("t6_no_early_press", n_prs, 0);
    tick(11, "t6_post_reset");
    check_val("t6_press_count", n_prs, 1);
    check_val("t6_repeat_count", n_rep, 1);
    cur_btn = '0;
    tick(8, "t6_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
- Parametrised N-channel push-button conditioner; the successor to the single-shot 5-button debouncer.
- Per channel it provides:
  - 2-flop input synchroniser
  - consecutive-sample debounce with a configurable window
  - registered level output
  - one-cycle press and release pulses
  - optional auto-repeat pulses for held buttons
- Sits between board pins (UP/DOWN/LEFT/RIGHT/CNTR) and the game/VGA/LCD control logic.
- Also reports a priority-encoded code of the highest pressed channel.

Parameters:
NUM_BTN, 5, number of independent button channels (>=1)
DEBOUNCE_CYCLES, 1000, consecutive synchronised samples a new level must hold before it is accepted (>=2)
REPEAT_DELAY, 25000000, cycles from oPress to the first oRepeat pulse (>=2)
REPEAT_PERIOD, 5000000, cycles between subsequent oRepeat pulses (>=2)
Localparams: DB_W = $clog2(DEBOUNCE_CYCLES); RP_W = $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)); CODE_W = max(1,$clog2(NUM_BTN)).

Ports:
Clock  in  1  system clock; all logic on posedge
Reset  in  1  synchronous reset, active-low (Reset==0 at a posedge clears all state)
iBtn  in  NUM_BTN  raw asynchronous button inputs, 1 = pressed
iRepeatEn  in  NUM_BTN  per-channel auto-repeat enable
oLevel  out  NUM_BTN  debounced level, registered
oPress  out  NUM_BTN  1-cycle pulse on accepted 0->1 transition
oRelease  out  NUM_BTN  1-cycle pulse on accepted 1->0 transition
oRepeat  out  NUM_BTN  1-cycle auto-repeat pulse while held
oAny  out  1  OR of oLevel (combinational from registers)
oCode  out  CODE_W  index of highest-numbered set oLevel bit; 0 when none

Behaviour:
- Reset (Reset==0 at posedge): sync flops, debounce counters, repeat counters, first-repeat flags and all outputs go to 0. oLevel=0 regardless of iBtn.
- Synchroniser: sync1<=iBtn[i]; s<=sync1. Only s feeds the debounce logic.
- Debounce, per channel:
  - If s==oLevel: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: oLevel<=s, cnt<=0.
  - Else: cnt<=cnt+1.
  - Any sample equal to oLevel restarts the window, so glitches shorter than DEBOUNCE_CYCLES are never accepted.
- Latency: iBtn stable from posedge k gives oLevel change at posedge k+DEBOUNCE_CYCLES+1.
  - oPress (or oRelease) is high for exactly that one cycle, coincident with the oLevel edge.
- oPress and oRelease of one channel are never high together.
- Channels are fully independent; simultaneous presses on several channels give simultaneous pulses.
- Auto-repeat, per channel, using rcnt and the first flag:
  - On the oPress cycle: rcnt<=0, first<=1.
  - While oLevel==1 && iRepeatEn==1: rcnt increments.
  - When first==1 && rcnt==REPEAT_DELAY-1: oRepeat pulses, rcnt<=0, first<=0.
  - When first==0 && rcnt==REPEAT_PERIOD-1: oRepeat pulses, rcnt<=0.
  - Result: first pulse at oPress edge + REPEAT_DELAY, then every REPEAT_PERIOD cycles.
  - iRepeatEn==0 or oLevel==0: rcnt<=0, first<=1, no oRepeat. Re-enabling while held restarts the REPEAT_DELAY wait.
  - No oRepeat on the oPress cycle or the oRelease cycle.
- Counter wrap: counters never exceed their compare value; no wrap-around is possible.
- Reset asserted mid-debounce or mid-repeat aborts the operation immediately. No pulse is emitted on the reset cycle or the first cycle after it.
- A button held through reset release must complete a full debounce window before oPress fires.
- oCode: priority encoder over oLevel, highest index wins. oAny and oCode both derive only from registered oLevel (glitch-free).

Test Plan (NUM_BTN=5, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
1. Hold Reset=0 for 3 cycles with iBtn=5'b11111 -> all outputs 0. Release reset -> oLevel=5'b11111 and oPress=5'b11111 exactly 5 posedges later (single cycle).
2. iBtn[2] bounce pattern 1,0,1,1,0,1,1,1,1 (one value per cycle) -> oLevel[2] rises only after the final 4-sample run, at posedge k+5 where k is the posedge where the final run of 1s begins. Exactly one oPress[2] pulse.
3. iBtn[0] pulses high for 3 cycles -> no oLevel/oPress/oRelease activity on any channel.
4. iRepeatEn[1]=1, hold iBtn[1] -> oPress at P, oRepeat at P+10, P+13, P+16… Release -> oRelease, no further oRepeat. Same test with iRepeatEn=0 -> no oRepeat.
5. Press channels 1 and 3 in the same cycle -> simultaneous oPress=5'b01010, oAny=1, oCode=3. Release channel 3 -> oCode=1. Release all -> oAny=0, oCode=0.
6. Assert Reset=0 while channel 4 is held mid-repeat (rcnt=5) -> next cycle all outputs 0. After release with button still held -> fresh oPress after 5 posedges, first oRepeat 10 cycles later.
